// File: rtl/adder_1_pkg.sv
// Shared result type and reference arithmetic for the single-bit full adder.
package adder_1_pkg;

   typedef struct packed {
      logic cout;
      logic sum;
   } fa_result_t;

   function automatic fa_result_t fa_add(input logic a, input logic b, input logic cin);
      logic [1:0] total;
      total = {1'b0, a} + {1'b0, b} + {1'b0, cin};
      return fa_result_t'(total);
   endfunction

endpackage

// File: rtl/adder_1_full_adder_cell.sv
// Purely combinational full adder cell; the building block of ripple-carry chains.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic prop;

   // Propagate term is shared between sum and carry.
   assign prop = a ^ b;
   assign sum  = prop ^ cin;
   assign cout = (a & b) | (cin & prop);

endmodule

// File: rtl/adder_1.sv
// Full adder with combinational outputs and a one-stage registered copy
// (synchronous, active-high reset on the registered copy only).
module adder_1
   import adder_1_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout,
   output logic sum_q,
   output logic cout_q
);

   logic sum_d;
   logic cout_d;

   full_adder_cell u_cell (
      .a    (a),
      .b    (b),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
   );

   always_comb begin
      sum_d  = sum;
      cout_d = cout;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q  <= 1'b0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

`ifndef SYNTHESIS
   fa_result_t exp_q;
   logic       armed_q;

   always_comb begin
      assert ($isunknown({a, b, cin}) || ({cout, sum} == fa_add(a, b, cin)));
   end

   // exp_q holds what the register should present after the current edge.
   always_ff @(posedge clk) begin
      if (armed_q === 1'b1) begin
         assert ($isunknown(exp_q) || ({cout_q, sum_q} == exp_q));
      end
      armed_q <= 1'b1;
      exp_q   <= rst ? fa_result_t'(2'b00) : fa_add(a, b, cin);
   end
`endif

endmodule

// File: tb/tb_adder_1.sv
// Scoreboard bench for adder_1: stimulus pushes expected results, a monitor pops and compares.
module tb_adder_1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a   = 1'b0;
   logic b   = 1'b0;
   logic cin = 1'b0;
   logic sum;
   logic cout;
   logic sum_q;
   logic cout_q;

   typedef struct {
      string      name;
      bit         reg_path;
      logic [1:0] exp;
   } sb_item_t;

   sb_item_t sb_q[$];
   int       n_run  = 0;
   int       n_fail = 0;

   adder_1 u_dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .sum    (sum),
      .cout   (cout),
      .sum_q  (sum_q),
      .cout_q (cout_q)
   );

   always #5 clk = ~clk;

   // Monitor: consumes each expectation while the stimulus holds the inputs steady.
   initial begin
      sb_item_t   item;
      logic [1:0] obs;
      forever begin
         wait (sb_q.size() != 0);
         item = sb_q.pop_front();
         obs  = item.reg_path ? {cout_q, sum_q} : {cout, sum};
         n_run++;
         if (obs !== item.exp) begin
            n_fail++;
            $display("FAIL %s: got {cout,sum}=%b, required %b at t=%0t",
                     item.name, obs, item.exp, $time);
         end
      end
   end

   task automatic expect_out(input string name, input bit reg_path, input logic [1:0] exp);
      sb_item_t item;
      item.name     = name;
      item.reg_path = reg_path;
      item.exp      = exp;
      sb_q.push_back(item);
      wait (sb_q.size() == 0);
   endtask

   // Hand-written truth table indexed by {a,b,cin}, value {cout,sum}.
   logic [1:0] truth [8];

   initial begin
      truth[0] = 2'b00; truth[1] = 2'b01; truth[2] = 2'b01; truth[3] = 2'b10;
      truth[4] = 2'b01; truth[5] = 2'b10; truth[6] = 2'b10; truth[7] = 2'b11;

      // Reset state with inputs at 000.
      @(posedge clk);
      @(posedge clk);
      #1;
      expect_out("reset_reg", 1'b1, 2'b00);
      expect_out("reset_comb", 1'b0, 2'b00);
      n_run++;
      if ({cout_q, sum_q} !== 2'b00) begin
         n_fail++;
         $display("FAIL direct_reset_reg: got %b at t=%0t", {cout_q, sum_q}, $time);
      end

      // Exhaustive static sweep, each combination held 5 units.
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         {a, b, cin} = v;
         #1;
         expect_out($sformatf("sweep_%b", v), 1'b0, truth[i]);
         #4;
      end

      // Registered path: 110 applied before an edge, no change until that edge.
      @(negedge clk);
      {a, b, cin} = 3'b000;
      @(posedge clk);
      #1;
      expect_out("reg_pre_000", 1'b1, 2'b00);
      @(negedge clk);
      {a, b, cin} = 3'b110;
      #1;
      expect_out("reg_hold_before_edge", 1'b1, 2'b00);
      expect_out("comb_110", 1'b0, 2'b10);
      n_run++;
      if ({cout, sum} !== 2'b10) begin
         n_fail++;
         $display("FAIL direct_comb_110: got %b at t=%0t", {cout, sum}, $time);
      end
      @(posedge clk);
      #1;
      expect_out("reg_110_after_edge", 1'b1, 2'b10);
      n_run++;
      if ({cout_q, sum_q} !== 2'b10) begin
         n_fail++;
         $display("FAIL direct_reg_110: got %b at t=%0t", {cout_q, sum_q}, $time);
      end

      // Reset held for two edges with inputs at 111.
      @(negedge clk);
      {a, b, cin} = 3'b111;
      rst = 1'b1;
      for (int e = 0; e < 2; e++) begin
         @(posedge clk);
         #1;
         expect_out($sformatf("rst111_reg_edge%0d", e), 1'b1, 2'b00);
         expect_out($sformatf("rst111_comb_edge%0d", e), 1'b0, 2'b11);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      expect_out("rst_release_reg", 1'b1, 2'b11);
      n_run++;
      if ({cout_q, sum_q} !== 2'b11) begin
         n_fail++;
         $display("FAIL direct_rst_release: got %b at t=%0t", {cout_q, sum_q}, $time);
      end

      // Free-running toggle run; edges fall at t0+8+10k, away from every toggle time.
      @(negedge clk);
      {a, b, cin} = 3'b000;
      @(posedge clk);
      #2;
      for (int t = 0; t <= 120; t++) begin
         if (t > 0 && t % 10 == 0) a = ~a;
         if (t > 0 && t % 15 == 0) b = ~b;
         if (t > 0 && t % 20 == 0) cin = ~cin;
         if (t == 63) rst = 1'b1;
         if (t == 71) rst = 1'b0;
         case (t)
            31: expect_out("toggle_t30", 1'b0, 2'b10);
            46: expect_out("toggle_t45", 1'b0, 2'b01);
            61: expect_out("toggle_t60_simultaneous", 1'b0, 2'b01);
            65: expect_out("midrst_reg_before", 1'b1, 2'b10);
            66: expect_out("midrst_comb_during", 1'b0, 2'b01);
            73: expect_out("midrst_reg_cleared", 1'b1, 2'b00);
            81: expect_out("midrst_reg_after", 1'b1, 2'b11);
            91: expect_out("toggle_t90", 1'b0, 2'b01);
            default: ;
         endcase
         if (t == 61) begin
            n_run++;
            if ({cout, sum} !== 2'b01) begin
               n_fail++;
               $display("FAIL direct_t60_simultaneous: got %b at t=%0t", {cout, sum}, $time);
            end
         end
         #1;
      end

      wait (sb_q.size() == 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, %0d run, %0d failed", n_run, n_fail);
      $fatal(1);
   end

endmodule
